// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg : shared types and IEEE-754 double classification for the FPU front end
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  localparam int FP_EXP_W  = 11;
  localparam int FP_FRAC_W = 52;

  typedef enum logic [2:0] {
    FP_ZERO      = 3'd0,
    FP_SUBNORMAL = 3'd1,
    FP_NORMAL    = 3'd2,
    FP_INF       = 3'd3,
    FP_QNAN      = 3'd4,
    FP_SNAN      = 3'd5
  } fp_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Takes the value without its sign bit: class never depends on the sign.
  function automatic fp_class_t fp_classify(input logic [FP_EXP_W+FP_FRAC_W-1:0] mag);
    logic [FP_EXP_W-1:0]  e;
    logic [FP_FRAC_W-1:0] f;
    e = mag[FP_FRAC_W +: FP_EXP_W];
    f = mag[FP_FRAC_W-1:0];
    if (e == '0)
      return (f == '0) ? FP_ZERO : FP_SUBNORMAL;
    else if (e == '1) begin
      if (f == '0)
        return FP_INF;
      return f[FP_FRAC_W-1] ? FP_QNAN : FP_SNAN;
    end
    return FP_NORMAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_operand_fifo.sv
// ----------------------------------------------------------------------------
// fpu_operand_fifo : small synchronous FIFO holding classified operand pairs
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_operand_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rdata = store[rd_ptr];
  assign full  = (used == LVL_W'(DEPTH));
  assign empty = (used == '0);
  assign level = used;

  // Callers only push when not full or when popping on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        store[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   used <= used + LVL_W'(1);
        2'b01:   used <= used - LVL_W'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_operand_fetch.sv
// ----------------------------------------------------------------------------
// fpu_operand_fetch : walks an address range, classifies operand pairs, feeds the FPU
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_operand_fetch
  import fpu_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [63:0]       op_a,
  output logic [63:0]       op_b,
  output logic [ADDR_W-1:0] op_idx,
  output logic [2:0]        op_cls_a,
  output logic [2:0]        op_cls_b
);

  localparam int PAY_W = DATA_W + ADDR_W + 3 + 3;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W:0]   remaining;
  fp_class_t         cls_a;
  fp_class_t         cls_b;
  logic [PAY_W-1:0]  wdata;
  logic [PAY_W-1:0]  rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              push;
  logic              pop;
  logic              drain_last;

  assign cls_a = fp_classify(mem_data[DATA_W-2:DATA_W/2]);
  assign cls_b = fp_classify(mem_data[DATA_W/2-2:0]);
  assign wdata = {mem_data, mem_addr, cls_a, cls_b};

  assign op_valid = !fifo_empty;
  assign pop      = op_valid && op_ready;
  assign push     = (state == ST_FETCH) && (!fifo_full || pop);
  // The buffer is empty after this edge: either already empty or losing its last entry.
  assign drain_last = fifo_empty || ((fifo_level == LVL_W'(1)) && pop);

  assign {op_a, op_b, op_idx, op_cls_a, op_cls_b} = rdata;

  fpu_operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              mem_addr  <= base_addr;
              remaining <= count;
              busy      <= 1'b1;
              state     <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          if (push) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1))
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_fpu_operand_fetch : directed scoreboard bench for the operand fetch sequencer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fpu_operand_fetch;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [12:0]   base_addr;
  logic [13:0]   count;
  logic          busy;
  logic          done;
  logic [12:0]   mem_addr;
  logic [127:0]  mem_data;
  logic          op_valid;
  logic          op_ready;
  logic [63:0]   op_a;
  logic [63:0]   op_b;
  logic [12:0]   op_idx;
  logic [2:0]    op_cls_a;
  logic [2:0]    op_cls_b;

  logic [127:0]  mem [8192];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [12:0] idx;
    logic [2:0]  ca;
    logic [2:0]  cb;
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  fpu_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_idx    (op_idx),
    .op_cls_a  (op_cls_a),
    .op_cls_b  (op_cls_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [12:0] addr, input logic [2:0] ca, input logic [2:0] cb);
    exp_t e;
    e.a   = mem[addr][127:64];
    e.b   = mem[addr][63:0];
    e.idx = addr;
    e.ca  = ca;
    e.cb  = cb;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns just after the accepting edge t0; the next negedge lies in cycle t0+1.
  task automatic run_start(input logic [12:0] b, input logic [13:0] n);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    count     = n;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  // Scoreboard: every head pair is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && op_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed=pair idx %0h expected=no pair", op_idx);
      end
      if (exp_q.size() > 0) begin
        check("sb_a",     op_a,     exp_q[0].a);
        check("sb_b",     op_b,     exp_q[0].b);
        check("sb_idx",   op_idx,   exp_q[0].idx);
        check("sb_cls_a", op_cls_a, exp_q[0].ca);
        check("sb_cls_b", op_cls_b, exp_q[0].cb);
        if (op_ready === 1'b1)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    op_ready  = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[0]    = {64'h400921FB54442D18, 64'h4000000000000000};
    mem[1]    = {64'hC008000000000000, 64'h3FF0000000000000};
    mem[2]    = {64'h3FF0000000000000, 64'h3FF0000000000000};
    mem[3]    = {64'h4000000000000000, 64'h3FF0000000000000};
    mem[5]    = {64'h7FF8000000000000, 64'h0000000000000001};
    mem[6]    = {64'hFFF0000000000000, 64'h7FF0000000000001};
    mem[8191] = {64'h3FF0000000000000, 64'h0000000000000000};

    // Reset values
    cyc(1);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_valid",    op_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 13'd0);
    check("rst_op_a",     op_a,     64'd0);
    check("rst_op_idx",   op_idx,   13'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal run: 4 pairs, ready held high
    for (int i = 0; i < 4; i++) push_exp(13'(i), 3'd2, 3'd2);
    run_start(13'd0, 14'd4);
    cyc(1);
    check("norm_busy_t1",  busy,     1'b1);
    check("norm_addr_t1",  mem_addr, 13'd0);
    check("norm_valid_t1", op_valid, 1'b0);
    cyc(1);
    check("norm_valid_t2", op_valid, 1'b1);
    check("norm_idx_t2",   op_idx,   13'd0);
    cyc(3);
    check("norm_idx_t5",   op_idx,   13'd3);
    check("norm_done_t5",  done,     1'b0);
    cyc(1);
    check("norm_done_t6",  done,     1'b1);
    check("norm_busy_t6",  busy,     1'b0);
    check("norm_valid_t6", op_valid, 1'b0);
    cyc(1);
    check("norm_done_t7",  done,     1'b0);
    check("norm_sb_empty", exp_q.size(), 0);

    // Back-pressure: ready low for cycles t0+2..t0+7
    op_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(13'(i), 3'd2, 3'd2);
    run_start(13'd0, 14'd4);
    cyc(3);
    check("bp_addr_t3",  mem_addr, 13'd2);
    check("bp_valid_t3", op_valid, 1'b1);
    cyc(4);
    check("bp_addr_t7",  mem_addr, 13'd2);
    check("bp_busy_t7",  busy,     1'b1);
    @(posedge clk);
    #1 op_ready = 1'b1;
    wait_done("bp_done", 40);
    check("bp_sb_empty", exp_q.size(), 0);

    // Address wrap
    push_exp(13'd8191, 3'd2, 3'd0);
    push_exp(13'd0,    3'd2, 3'd2);
    run_start(13'd8191, 14'd2);
    cyc(2);
    check("wrap_idx_first",  op_idx, 13'd8191);
    cyc(1);
    check("wrap_idx_second", op_idx, 13'd0);
    wait_done("wrap_done", 20);
    check("wrap_sb_empty", exp_q.size(), 0);

    // Classification: qNaN/subnormal, inf/sNaN
    push_exp(13'd5, 3'd4, 3'd1);
    push_exp(13'd6, 3'd3, 3'd5);
    run_start(13'd5, 14'd2);
    wait_done("cls_done", 20);
    check("cls_sb_empty", exp_q.size(), 0);

    // count = 0
    run_start(13'd100, 14'd0);
    cyc(1);
    check("zero_done_t1",  done,     1'b1);
    check("zero_busy_t1",  busy,     1'b0);
    check("zero_valid_t1", op_valid, 1'b0);
    cyc(1);
    check("zero_done_t2",  done,     1'b0);
    check("zero_busy_t2",  busy,     1'b0);
    check("zero_valid_t2", op_valid, 1'b0);

    // start pulsed while busy is ignored
    for (int i = 0; i < 4; i++) push_exp(13'(i), 3'd2, 3'd2);
    run_start(13'd0, 14'd4);
    cyc(1);
    start     = 1'b1;
    base_addr = 13'd5;
    count     = 14'd1;
    cyc(1);
    start     = 1'b0;
    cyc(3);
    check("ign_idx_t5",  op_idx, 13'd3);
    cyc(1);
    check("ign_done_t6", done,   1'b1);
    cyc(2);
    check("ign_valid_after", op_valid, 1'b0);
    check("ign_busy_after",  busy,     1'b0);
    check("ign_sb_empty",    exp_q.size(), 0);

    // Asynchronous reset mid-FETCH with one entry buffered
    op_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(13'(i), 3'd2, 3'd2);
    run_start(13'd0, 14'd4);
    cyc(2);
    check("mid_valid_t2", op_valid, 1'b1);
    check("mid_addr_t2",  mem_addr, 13'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy,     1'b0);
    check("mid_rst_done",  done,     1'b0);
    check("mid_rst_valid", op_valid, 1'b0);
    check("mid_rst_addr",  mem_addr, 13'd0);
    check("mid_rst_a",     op_a,     64'd0);
    check("mid_rst_b",     op_b,     64'd0);
    check("mid_rst_idx",   op_idx,   13'd0);
    check("mid_rst_cls",   {op_cls_a, op_cls_b}, 6'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("post_rst_done",  done,     1'b0);
      check("post_rst_busy",  busy,     1'b0);
      check("post_rst_valid", op_valid, 1'b0);
    end

    check("final_sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
